// File: rtl/ex_div_unit_if.sv
// EX-stage divider interface: operand/control inputs from the pipeline and
// the hold/result signals going back to it.
interface ex_div_unit_if #(parameter int DATA_W = 32);
   logic              flush;
   logic              valid_in;
   logic              div_en;
   logic [1:0]        div_op;
   logic [DATA_W-1:0] src1;
   logic [DATA_W-1:0] src2;
   logic              suspend;
   logic              busy;
   logic [DATA_W-1:0] result;
   logic              result_valid;

   modport master (
      output flush, valid_in, div_en, div_op, src1, src2,
      input  suspend, busy, result, result_valid
   );

   modport slave (
      input  flush, valid_in, div_en, div_op, src1, src2,
      output suspend, busy, result, result_valid
   );
endinterface

// File: rtl/ex_div_unit.sv
// Iterative restoring radix-2 divider for DIV.W/MOD.W/DIV.WU/MOD.WU that
// stalls the upstream pipeline while a division is in flight.
module ex_div_unit #(
   parameter int DATA_W = 32
) (
   input  logic           cpu_clk,
   input  logic           cpu_rst,
   ex_div_unit_if.slave   bus
);
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  count_reg;
   logic [DATA_W-1:0] rem_reg, quo_reg, divisor_reg, result_reg;
   logic [1:0]        op_reg;
   logic              q_neg_reg, r_neg_reg;

   logic              start;
   logic              op_signed;
   logic [DATA_W-1:0] src1_mag, src2_mag;
   logic [DATA_W:0]   shifted, trial;
   logic [DATA_W-1:0] rem_step, quo_step, final_q, final_r;

   assign start     = bus.valid_in & bus.div_en & ~bus.flush & (state_reg == IDLE);
   assign op_signed = ~bus.div_op[1];
   // Wrap negation: |0x80000000| stays 0x80000000, which the unsigned core handles.
   assign src1_mag  = (op_signed & bus.src1[DATA_W-1]) ? ('0 - bus.src1) : bus.src1;
   assign src2_mag  = (op_signed & bus.src2[DATA_W-1]) ? ('0 - bus.src2) : bus.src2;

   assign shifted  = {rem_reg, quo_reg[DATA_W-1]};
   assign trial    = shifted - {1'b0, divisor_reg};
   assign rem_step = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
   assign quo_step = {quo_reg[DATA_W-2:0], ~trial[DATA_W]};
   assign final_q  = q_neg_reg ? ('0 - quo_step) : quo_step;
   assign final_r  = r_neg_reg ? ('0 - rem_step) : rem_step;

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) state_reg <= IDLE;
      else         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start) state_next = (bus.src2 == '0) ? DONE : BUSY;
         BUSY: if (count_reg == LAST) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (bus.flush) state_next = IDLE;
   end

   always_comb begin
      bus.suspend      = 1'b0;
      bus.busy         = (state_reg != IDLE);
      bus.result_valid = (state_reg == DONE);
      bus.result       = result_reg;
      case (state_reg)
         IDLE:    bus.suspend = start & ~cpu_rst;
         BUSY:    bus.suspend = ~bus.flush & ~cpu_rst;
         default: bus.suspend = 1'b0;
      endcase
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         count_reg   <= '0;
         rem_reg     <= '0;
         quo_reg     <= '0;
         divisor_reg <= '0;
         result_reg  <= '0;
         op_reg      <= '0;
         q_neg_reg   <= 1'b0;
         r_neg_reg   <= 1'b0;
      end else if (start) begin
         count_reg   <= '0;
         rem_reg     <= '0;
         quo_reg     <= src1_mag;
         divisor_reg <= src2_mag;
         op_reg      <= bus.div_op;
         q_neg_reg   <= op_signed & (bus.src1[DATA_W-1] ^ bus.src2[DATA_W-1]);
         r_neg_reg   <= op_signed & bus.src1[DATA_W-1];
         // Divide by zero bypasses the iteration with fixed, unsigned-style results.
         if (bus.src2 == '0)
            result_reg <= bus.div_op[0] ? bus.src1 : '1;
      end else if (state_reg == BUSY && !bus.flush) begin
         rem_reg   <= rem_step;
         quo_reg   <= quo_step;
         count_reg <= count_reg + CNT_W'(1);
         if (count_reg == LAST)
            result_reg <= op_reg[0] ? final_r : final_q;
      end
   end
endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: directed and random divides checked
// against a plain-arithmetic reference, plus flush/reset/timing checks.
module tb_ex_div_unit;
   localparam int DATA_W = 32;

   logic cpu_clk = 1'b0;
   logic cpu_rst = 1'b1;
   always #5 cpu_clk = ~cpu_clk;

   ex_div_unit_if #(.DATA_W(DATA_W)) bus ();

   ex_div_unit #(.DATA_W(DATA_W)) dut (
      .cpu_clk (cpu_clk),
      .cpu_rst (cpu_rst),
      .bus     (bus)
   );

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_exp = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'h0) return op[0] ? a : 32'hFFFF_FFFF;
      if (op[1]) return op[0] ? (a % b) : (a / b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      return op[0] ? r[31:0] : q[31:0];
   endfunction

   // Monitor: every result_valid pulse must match the oldest queued expectation.
   always @(negedge cpu_clk) begin
      if (!cpu_rst && bus.result_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_result_valid actual=0x%08h required=no pulse", bus.result);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (bus.result !== e) begin
               failures++;
               $display("FAIL result actual=0x%08h required=0x%08h", bus.result, e);
            end else
               $display("result ok 0x%08h", e);
         end
      end
   end

   // Issue one divide at the current (low) clock phase and follow its timing.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int cyc;
      int lat;
      logic [31:0] e;
      e   = ref_div(op, a, b);
      lat = (b == 32'h0) ? 1 : 33;
      exp_q.push_back(e);
      last_exp = e;
      $display("issue op=%0d src1=0x%08h src2=0x%08h expect=0x%08h", op, a, b, e);
      bus.valid_in = 1'b1;
      bus.div_en   = 1'b1;
      bus.div_op   = op;
      bus.src1     = a;
      bus.src2     = b;
      #1 chk("suspend_t0", {31'b0, bus.suspend}, 32'd1);
      @(posedge cpu_clk);
      #1;
      bus.valid_in = 1'b0;
      bus.div_op   = 2'($urandom_range(0, 3));
      bus.src1     = $urandom;
      bus.src2     = $urandom;
      cyc = 0;
      while (cyc < 40) begin
         @(negedge cpu_clk);
         cyc++;
         if (bus.result_valid === 1'b1) break;
         if (bus.suspend !== 1'b1 || bus.busy !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL busy_phase cycle=%0d suspend=%b busy=%b required=1,1",
                     cyc, bus.suspend, bus.busy);
         end
      end
      chk("latency", cyc, lat);
      chk("suspend_done", {31'b0, bus.suspend}, 32'd0);
      chk("busy_done", {31'b0, bus.busy}, 32'd1);
      @(negedge cpu_clk);
      chk("busy_after", {31'b0, bus.busy}, 32'd0);
      chk("valid_after", {31'b0, bus.result_valid}, 32'd0);
   endtask

   logic [31:0] edge_vals [6];

   initial begin
      edge_vals[0] = 32'h0000_0000; edge_vals[1] = 32'h0000_0001;
      edge_vals[2] = 32'hFFFF_FFFF; edge_vals[3] = 32'h8000_0000;
      edge_vals[4] = 32'h7FFF_FFFF; edge_vals[5] = 32'h0000_0010;
      bus.flush = 1'b0; bus.valid_in = 1'b1; bus.div_en = 1'b1;
      bus.div_op = 2'b00; bus.src1 = 32'd10; bus.src2 = 32'd3;

      // Reset state, including suspend held low against a start candidate.
      @(negedge cpu_clk);
      chk("rst_suspend", {31'b0, bus.suspend}, 32'd0);
      chk("rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("rst_valid", {31'b0, bus.result_valid}, 32'd0);
      chk("rst_result", bus.result, 32'd0);
      bus.valid_in = 1'b0;
      cpu_rst = 1'b0;
      @(negedge cpu_clk);

      // Directed cases.
      do_op(2'b00, 32'd100, 32'd7);
      do_op(2'b00, -32'sd7, 32'd2);
      do_op(2'b01, -32'sd7, 32'd2);
      do_op(2'b00, 32'd7, -32'sd2);
      do_op(2'b01, 32'd7, -32'sd2);
      do_op(2'b10, 32'hFFFF_FFFF, 32'd2);
      do_op(2'b11, 32'hFFFF_FFFF, 32'h10);
      do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op(2'b00, 32'd5, 32'd0);
      do_op(2'b11, 32'h1234_5678, 32'd0);
      do_op(2'b01, -32'sd9, 32'd0);

      // Flush mid-operation at T10.
      bus.valid_in = 1'b1; bus.div_en = 1'b1; bus.div_op = 2'b00;
      bus.src1 = 32'd1000; bus.src2 = 32'd3;
      @(posedge cpu_clk);
      #1 bus.valid_in = 1'b0;
      repeat (9) @(negedge cpu_clk);
      bus.flush = 1'b1;
      #1 chk("flush_suspend", {31'b0, bus.suspend}, 32'd0);
      @(negedge cpu_clk);
      bus.flush = 1'b0;
      chk("flush_busy", {31'b0, bus.busy}, 32'd0);
      chk("flush_valid", {31'b0, bus.result_valid}, 32'd0);
      chk("flush_result", bus.result, last_exp);
      // Flush alongside a start candidate in IDLE: nothing begins.
      bus.valid_in = 1'b1; bus.flush = 1'b1;
      #1 chk("flush_idle_suspend", {31'b0, bus.suspend}, 32'd0);
      @(negedge cpu_clk);
      bus.valid_in = 1'b0; bus.flush = 1'b0;
      chk("flush_idle_busy", {31'b0, bus.busy}, 32'd0);
      do_op(2'b10, 32'd9, 32'd3);

      // Asynchronous reset mid-operation.
      bus.valid_in = 1'b1; bus.div_op = 2'b00; bus.src1 = 32'd77; bus.src2 = 32'd5;
      @(posedge cpu_clk);
      #1 bus.valid_in = 1'b0;
      repeat (4) @(posedge cpu_clk);
      #2 cpu_rst = 1'b1;
      #1;
      chk("arst_busy", {31'b0, bus.busy}, 32'd0);
      chk("arst_suspend", {31'b0, bus.suspend}, 32'd0);
      chk("arst_valid", {31'b0, bus.result_valid}, 32'd0);
      chk("arst_result", bus.result, 32'd0);
      last_exp = 32'd0;
      @(negedge cpu_clk);
      cpu_rst = 1'b0;
      @(negedge cpu_clk);
      do_op(2'b00, 32'd20, 32'd4);
      do_op(2'b01, 32'd20, 32'd6);

      // Random operations with edge-value mixing.
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1, 2:    b = edge_vals[$urandom_range(1, 5)];
            3, 4:    b = $urandom_range(1, 300);
            default: b = $urandom;
         endcase
         do_op(2'($urandom_range(0, 3)), a, b);
      end

      repeat (3) @(negedge cpu_clk);
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
